// File: rtl/minila_inst_encoder_if.sv
// miniLA encoder bus: instruction field stream in, IROM write port out.
// Encoder is the slave of the stream and master of the IROM port.
interface minila_inst_encoder_if #(
  parameter int ADDR_W = 14
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rj;
  logic [4:0]        in_rk;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              irom_we;
  logic [ADDR_W-1:0] irom_addr;
  logic [31:0]       irom_wdata;
  logic              irom_ack;

  modport master (
    output in_valid, in_op, in_rd, in_rj,
    output in_rk, in_imm, in_last, irom_ack,
    input  in_ready, irom_we, irom_addr,
    input  irom_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rj,
    input  in_rk, in_imm, in_last, irom_ack,
    output in_ready, irom_we, irom_addr,
    output irom_wdata
  );
endinterface

// File: rtl/minila_inst_encoder.sv
// miniLA instruction encoder / IROM program loader.
// Packs symbolic fields into 32-bit words and streams them into IROM.
module minila_inst_encoder #(
  parameter int ADDR_W = 14
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  minila_inst_encoder_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_W-1:0]     err_addr,
  output logic [ADDR_W:0]       inst_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic        in_ready;
  logic        accept;
  logic [31:0] enc_word;
  logic        enc_ok;

  logic [5:0]  op;
  logic [31:0] imm;
  logic [31:0] offs;
  logic        cls_3r, cls_si, cls_sh;
  logic        cls_br, cls_b;
  logic        si_ok, sh_ok, br_ok, b_ok;

  assign op   = bus.in_op;
  assign imm  = bus.in_imm;
  assign offs = {{2{imm[31]}}, imm[31:2]};

  assign cls_3r = (op <= 6'd6);
  assign cls_si = (op >= 6'd8 && op <= 6'd13)
               || op == 6'd17 || op == 6'd18;
  assign cls_sh = (op >= 6'd14 && op <= 6'd16);
  assign cls_br = (op >= 6'd22 && op <= 6'd25)
               || op == 6'd19;
  assign cls_b  = (op == 6'd20 || op == 6'd21);

  assign si_ok = imm[31:11] == {21{imm[11]}};
  assign sh_ok = imm[31:5] == 27'd0;
  assign br_ok = imm[1:0] == 2'd0
              && offs[31:15] == {17{offs[15]}};
  assign b_ok  = imm[1:0] == 2'd0
              && offs[31:25] == {7{offs[25]}};

  always_comb begin
    enc_word = 32'd0;
    enc_ok   = 1'b0;
    unique case (1'b1)
      cls_3r: begin
        enc_ok   = 1'b1;
        enc_word = {op, 11'd0, bus.in_rk,
                    bus.in_rj, bus.in_rd};
      end
      cls_si: begin
        enc_ok   = si_ok;
        enc_word = {op, 4'd0, imm[11:0],
                    bus.in_rj, bus.in_rd};
      end
      cls_sh: begin
        enc_ok   = sh_ok;
        enc_word = {op, 11'd0, imm[4:0],
                    bus.in_rj, bus.in_rd};
      end
      cls_br: begin
        enc_ok   = br_ok;
        enc_word = {op, offs[15:0],
                    bus.in_rj, bus.in_rd};
      end
      cls_b: begin
        enc_ok   = b_ok;
        enc_word = {op, offs[15:0], offs[25:16]};
      end
      default: begin
        enc_ok   = 1'b0;
        enc_word = 32'd0;
      end
    endcase
  end

  assign in_ready = (state_q == RUN)
                 && (!we_q || bus.irom_ack);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    cnt_d      = cnt_q;

    if (we_q && bus.irom_ack) begin
      we_d   = 1'b0;
      addr_d = addr_q + ADDR_W'(1);
      cnt_d  = cnt_q + (ADDR_W+1)'(1);
    end

    if (accept) begin
      if (enc_ok) begin
        we_d    = 1'b1;
        wdata_d = enc_word;
      end else begin
        err_d = 1'b1;
        // slot the word would take once any in-flight write retires
        if (!err_q)
          err_addr_d = we_q ? addr_q + ADDR_W'(1)
                            : addr_q;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          addr_d     = base_addr;
          err_d      = 1'b0;
          err_addr_d = '0;
          cnt_d      = '0;
        end
      end
      RUN: begin
        if (accept && bus.in_last)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (!we_q)
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.irom_we    = we_q;
  assign bus.irom_addr  = addr_q;
  assign bus.irom_wdata = wdata_q;

  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign err_addr = err_addr_q;
  assign inst_cnt = cnt_q;

endmodule

// File: tb/tb_minila_inst_encoder.sv
// Directed bench for minila_inst_encoder.
// Hand-computed words, IROM write monitor, per-scenario tasks.
module tb_minila_inst_encoder;
  localparam int AW = 14;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy, done, err;
  logic [AW-1:0] err_addr;
  logic [AW:0]   inst_cnt;

  minila_inst_encoder_if #(.ADDR_W(AW)) bus ();

  minila_inst_encoder #(.ADDR_W(AW)) dut (
    .cpu_clk   (clk),
    .cpu_rst_n (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_addr  (err_addr),
    .inst_cnt  (inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            wc_q[$];

  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.irom_we && bus.irom_ack) begin
      wa_q.push_back(bus.irom_addr);
      wd_q.push_back(bus.irom_wdata);
      wc_q.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic clr_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  task automatic send(input logic [5:0] op,
                      input logic [4:0] rd,
                      input logic [4:0] rj,
                      input logic [4:0] rk,
                      input logic [31:0] imm,
                      input logic last);
    bit ok;
    int n;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rj    = rj;
    bus.in_rk    = rk;
    bus.in_imm   = imm;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 40) begin
      #1;
      ok = bus.in_ready;
      @(posedge clk);
      if (!ok) @(negedge clk);
      n++;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed %b, want 1", ok);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic open_session(input logic [AW-1:0] b);
    start     = 1'b1;
    base_addr = b;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done_cnt == d0) begin
      fails++;
      $display("FAIL done_timeout: done count %0d, want %0d", done_cnt, d0 + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.irom_we !== 1'b0) begin
      fails++;
      $display("FAIL rst_we: got %b want 0", bus.irom_we);
    end
    tests++;
    if (bus.irom_addr !== 14'd0) begin
      fails++;
      $display("FAIL rst_addr: got %h want 0", bus.irom_addr);
    end
    tests++;
    if ({busy, done, err, bus.in_ready} !== 4'b0) begin
      fails++;
      $display("FAIL rst_flags: got %b want 0000", {busy, done, err, bus.in_ready});
    end
    tests++;
    if (inst_cnt !== 15'd0 || err_addr !== 14'd0) begin
      fails++;
      $display("FAIL rst_cnt: got %h/%h want 0/0", inst_cnt, err_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    int d0;
    clr_log();
    bus.irom_ack = 1'b1;
    d0 = done_cnt;
    open_session(14'h010);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    send(6'b000000, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    send(6'b001000, 5'd4, 5'd5, 5'd0, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    tests++;
    if (wa_q.size() != 2) begin
      fails++;
      $display("FAIL basic_nwr: got %0d want 2", wa_q.size());
    end else begin
      tests++;
      if (wa_q[0] !== 14'h010 || wd_q[0] !== 32'h0000_0C41) begin
        fails++;
        $display("FAIL basic_w0: got %h@%h want 00000c41@0010", wd_q[0], wa_q[0]);
      end
      tests++;
      if (wa_q[1] !== 14'h011 || wd_q[1] !== 32'h203F_FCA4) begin
        fails++;
        $display("FAIL basic_w1: got %h@%h want 203ffca4@0011", wd_q[1], wa_q[1]);
      end
    end
    tests++;
    if (done_cnt !== d0 + 1) begin
      fails++;
      $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0);
    end
    tests++;
    if (inst_cnt !== 15'd2 || err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_status: cnt %0d err %b busy %b want 2 0 0", inst_cnt, err, busy);
    end
  endtask

  task automatic test_branch();
    clr_log();
    bus.irom_ack = 1'b1;
    open_session(14'h100);
    send(6'b010101, 5'd5, 5'd0, 5'd0, 32'd8, 1'b0);
    send(6'b010101, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0);
    send(6'b010110, 5'd2, 5'd1, 5'd0, 32'hFFFF_FFF8, 1'b1);
    wait_done();
    tests++;
    if (wa_q.size() != 3) begin
      fails++;
      $display("FAIL br_nwr: got %0d want 3", wa_q.size());
    end else begin
      tests++;
      if (wd_q[0] !== 32'h5400_0800) begin
        fails++;
        $display("FAIL br_b_pos: got %h want 54000800", wd_q[0]);
      end
      tests++;
      if (wd_q[1] !== 32'h57FF_FFFF) begin
        fails++;
        $display("FAIL br_b_neg: got %h want 57ffffff", wd_q[1]);
      end
      tests++;
      if (wd_q[2] !== 32'h5BFF_F822 || wa_q[2] !== 14'h102) begin
        fails++;
        $display("FAIL br_beq: got %h@%h want 5bfff822@0102", wd_q[2], wa_q[2]);
      end
    end
  endtask

  task automatic test_errors();
    clr_log();
    bus.irom_ack = 1'b1;
    open_session(14'h200);
    send(6'b001110, 5'd1, 5'd2, 5'd0, 32'd32, 1'b0);
    send(6'b010111, 5'd1, 5'd2, 5'd0, 32'd6, 1'b0);
    send(6'b111111, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    send(6'b001101, 5'd1, 5'd2, 5'd0, 32'd5, 1'b1);
    wait_done();
    tests++;
    if (wa_q.size() != 1) begin
      fails++;
      $display("FAIL err_nwr: got %0d want 1", wa_q.size());
    end else begin
      tests++;
      if (wa_q[0] !== 14'h200 || wd_q[0] !== 32'h3400_1441) begin
        fails++;
        $display("FAIL err_ori: got %h@%h want 34001441@0200", wd_q[0], wa_q[0]);
      end
    end
    tests++;
    if (err !== 1'b1 || err_addr !== 14'h200 || inst_cnt !== 15'd1) begin
      fails++;
      $display("FAIL err_status: err %b addr %h cnt %0d want 1 0200 1", err, err_addr, inst_cnt);
    end
  endtask

  task automatic test_backpressure();
    clr_log();
    bus.irom_ack = 1'b0;
    open_session(14'h300);
    send(6'b000000, 5'd7, 5'd8, 5'd9, 32'd0, 1'b0);
    bus.in_op    = 6'b001110;
    bus.in_rd    = 5'd1;
    bus.in_rj    = 5'd2;
    bus.in_rk    = 5'd0;
    bus.in_imm   = 32'd31;
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if ({bus.irom_we, bus.in_ready} !== 2'b10 || bus.irom_addr !== 14'h300
          || bus.irom_wdata !== 32'h0000_2507) begin
        fails++;
        $display("FAIL bp_hold%0d: we/rdy %b%b %h@%h want 10 00002507@0300",
                 k, bus.irom_we, bus.in_ready, bus.irom_wdata, bus.irom_addr);
      end
      @(negedge clk);
    end
    bus.irom_ack = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_ready: got %b want 1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done();
    tests++;
    if (wa_q.size() != 2) begin
      fails++;
      $display("FAIL bp_nwr: got %0d want 2", wa_q.size());
    end else begin
      tests++;
      if (wa_q[0] !== 14'h300 || wd_q[0] !== 32'h0000_2507
          || wa_q[1] !== 14'h301 || wd_q[1] !== 32'h3800_7C41) begin
        fails++;
        $display("FAIL bp_order: got %h@%h %h@%h want 00002507@0300 38007c41@0301",
                 wd_q[0], wa_q[0], wd_q[1], wa_q[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clr_log();
    bus.irom_ack = 1'b1;
    open_session(14'h3FFF);
    send(6'b000001, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
    start     = 1'b1;
    base_addr = 14'h0;
    send(6'b010001, 5'd2, 5'd3, 5'd0, 32'd4, 1'b0);
    start = 1'b0;
    send(6'b010100, 5'd0, 5'd0, 5'd0, 32'h100, 1'b1);
    wait_done();
    tests++;
    if (wa_q.size() != 3) begin
      fails++;
      $display("FAIL wrap_nwr: got %0d want 3", wa_q.size());
    end else begin
      tests++;
      if (wa_q[0] !== 14'h3FFF || wa_q[1] !== 14'h0000 || wa_q[2] !== 14'h0001) begin
        fails++;
        $display("FAIL wrap_addr: got %h %h %h want 3fff 0000 0001", wa_q[0], wa_q[1], wa_q[2]);
      end
      tests++;
      if (wd_q[0] !== 32'h0400_0421 || wd_q[1] !== 32'h4400_1062
          || wd_q[2] !== 32'h5001_0000) begin
        fails++;
        $display("FAIL wrap_data: got %h %h %h want 04000421 44001062 50010000",
                 wd_q[0], wd_q[1], wd_q[2]);
      end
      tests++;
      if (wc_q[1] - wc_q[0] != 1 || wc_q[2] - wc_q[1] != 1) begin
        fails++;
        $display("FAIL wrap_rate: gaps %0d %0d want 1 1", wc_q[1] - wc_q[0], wc_q[2] - wc_q[1]);
      end
    end
    tests++;
    if (inst_cnt !== 15'd3) begin
      fails++;
      $display("FAIL wrap_cnt: got %0d want 3", inst_cnt);
    end
  endtask

  task automatic test_mid_reset();
    clr_log();
    bus.irom_ack = 1'b0;
    open_session(14'h040);
    send(6'b111111, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    send(6'b000000, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    #1;
    tests++;
    if (bus.irom_we !== 1'b1 || err !== 1'b1) begin
      fails++;
      $display("FAIL mr_pre: we %b err %b want 1 1", bus.irom_we, err);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if ({bus.irom_we, busy, err} !== 3'b000 || inst_cnt !== 15'd0) begin
      fails++;
      $display("FAIL mr_post: we/busy/err %b cnt %0d want 000 0",
               {bus.irom_we, busy, err}, inst_cnt);
    end
    bus.irom_ack = 1'b1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      tests++;
      if (bus.in_ready !== 1'b0 || bus.irom_we !== 1'b0) begin
        fails++;
        $display("FAIL mr_ignore%0d: rdy %b we %b want 0 0", k, bus.in_ready, bus.irom_we);
      end
    end
    bus.in_valid = 1'b0;
    tests++;
    if (wa_q.size() != 0) begin
      fails++;
      $display("FAIL mr_nwr: got %0d want 0", wa_q.size());
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    base_addr    = '0;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_rd    = '0;
    bus.in_rj    = '0;
    bus.in_rk    = '0;
    bus.in_imm   = '0;
    bus.in_last  = 1'b0;
    bus.irom_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_branch();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/minila_inst_encoder.md
Name: minila_inst_encoder

Overview:
- Instruction encoder and program loader for the miniLA single-cycle core: performs the inverse of instruction decode.
- Accepts symbolic instruction fields (opcode, registers, byte-level immediate) over a valid/ready stream.
- Range-checks the fields, packs them into 32-bit miniLA words, and writes them sequentially into instruction ROM through an ack-handshaked write port.
- Used by the trace/self-test bench and the boot loader to build programs.

Parameters:
ADDR_W, 14, IROM word-address width; address counter wraps modulo 2^ADDR_W

Ports:
cpu_clk  in  1  clock; all logic on rising edge
cpu_rst_n  in  1  synchronous reset, active low
start  in  1  one-cycle pulse: open a load session at base_addr (honoured only in IDLE)
base_addr  in  ADDR_W  first IROM word address of the session
in_valid  in  1  instruction fields valid
in_ready  out  1  encoder can accept this cycle
in_op  in  6  miniLA opcode (inst[31:26])
in_rd  in  5  rd
in_rj  in  5  rj
in_rk  in  5  rk
in_imm  in  32  signed immediate; byte offset for branches and jumps, shift amount for shifts
in_last  in  1  marks final instruction of the session
irom_we  out  1  write request, held until acked
irom_addr  out  ADDR_W  word address
irom_wdata  out  32  encoded instruction
irom_ack  in  1  IROM accepts the write this cycle
busy  out  1  session open (RUN or DRAIN)
done  out  1  one-cycle pulse when the session completes
err  out  1  sticky; some instruction in the session was rejected
err_addr  out  ADDR_W  irom address the first rejected instruction would have used
inst_cnt  out  ADDR_W+1  words written this session

Behaviour:
- Reset: all outputs 0; state IDLE; address counter 0.
- States:
  - IDLE: start -> RUN. On start, load addr=base_addr, clear err, err_addr and inst_cnt.
  - RUN: in_ready = !irom_we | irom_ack. An accepted instruction with in_last=1 -> DRAIN.
  - DRAIN: in_ready=0; wait until the output register is empty -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start outside IDLE is ignored. in_valid outside RUN is ignored (in_ready=0).
- Pipelining: accept at cycle N (in_valid & in_ready) -> irom_we=1 from N+1 with the registered word and the current addr.
  - irom_we/addr/wdata are held stable until irom_ack.
  - An ack and a new accept in the same cycle give back-to-back writes: 1 word/cycle sustained.
- addr and inst_cnt increment by 1 on each ack. addr wraps 2^ADDR_W-1 -> 0 silently.
- Field placement: op[31:26], rd[4:0], rj[9:5], rk[14:10]. Unused bits are 0.
- Per-opcode encoding:
  - 3R, 000000-000110: rk, rj, rd.
  - si12, 001000-001101 and 010001/010010 (ld.w/st.w): imm[11:0] at [21:10]; legal range -2048..2047.
  - Shift, 001110-010000: imm[4:0] at [14:10]; legal range 0..31.
  - Branches 010110-011001 and jirl 010011: offs=imm>>>2 at [25:10]. imm[1:0] must be 0; offs must fit 16-bit signed.
  - b 010101 and bl 010100: offs=imm>>>2; offs[15:0] at [25:10], offs[25:16] at [9:0]. imm[1:0] must be 0; offs must fit 26-bit signed. rd is ignored.
- Reject conditions: unlisted opcode, out-of-range immediate, misaligned offset.
  - A rejected instruction is consumed (in_ready handshake completes) but no write is issued; addr does not advance.
  - err is set. err_addr captures the current addr only on the first rejection of the session.
  - A rejected instruction with in_last=1 still closes the session (DRAIN -> DONE).
- Reset mid-session: a pending write is dropped immediately; return to IDLE.

Test Plan:
- Basic encode: start with base 0x010; send add.w r1,r2,r3 (op 000000) then addi.w r4,r5,imm=-1 (op 001000, last) -> writes 0x00000C41 @0x010 and 0x203FFCA4 @0x011; done pulses once; inst_cnt=2; err=0.
- Branch offsets: b with imm=+8 -> 0x54000800; b with imm=-4 -> 0x57FFFFFF; beq rj=1,rd=2,imm=-8 -> 0x5BFFF822.
- Errors: slli.w imm=32, then bne imm=6, then op 111111, then valid ori -> only the ori is written, at base_addr; err=1; err_addr=base_addr; inst_cnt=1.
- Backpressure: irom_ack held low 3 cycles with 2 instructions queued -> irom_we/addr/wdata stable, in_ready=0 while full; both words land in order; no loss or duplication.
- Wrap and throughput: base 2^ADDR_W-1 with irom_ack tied high, 3 back-to-back instructions -> addresses 0x3FFF, 0x0000, 0x0001 on consecutive cycles; start asserted while busy is ignored.
- Reset mid-session: cpu_rst_n low for 1 cycle while irom_we=1 -> next cycle irom_we=0, busy=0, err=0, inst_cnt=0; in_valid then ignored until the next start.
